init_fill: RTL and testbench



---
 rtl/init_fill_pkg.sv | 17 +
 rtl/init_fill_pattern_gen.sv | 30 +++
 rtl/init_fill.sv | 112 +++++++++++
 tb/tb_init_fill.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/init_fill_pkg.sv
// Shared types for the init_fill memory initialiser: pattern select and FSM states.
package init_fill_pkg;

  typedef enum logic [1:0] {
    IDENTITY = 2'b00,
    CONST    = 2'b01,
    RAMP     = 2'b10,
    REVERSE  = 2'b11
  } fill_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/init_fill_pattern_gen.sv
// Combinational pattern generator: maps (mode, idx, acc, base) to the word written at idx.
module init_pattern_gen
  import init_fill_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  fill_mode_t        mode,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] wrdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // RAMP reuses the running accumulator so no multiplier is needed.
  always_comb begin
    wrdata = '0;
    case (mode)
      IDENTITY: wrdata = DATA_W'(idx);
      CONST:    wrdata = base;
      RAMP:     wrdata = acc;
      REVERSE:  wrdata = DATA_W'(LAST_IDX - idx);
      default:  wrdata = '0;
    endcase
  end

endmodule

// File: rtl/init_fill.sv
// Fills a DEPTH-entry memory with a selectable pattern, one word per cycle,
// with en/rdy start handshake, stall back-pressure and a one-cycle done pulse.
module init_fill
  import init_fill_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] stride,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] idx_q,    idx_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  fill_mode_t        mode_q,   mode_d;
  logic [DATA_W-1:0] base_q,   base_d;
  logic [DATA_W-1:0] stride_q, stride_d;
  logic [DATA_W-1:0] pat_data;

  init_pattern_gen #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pattern (
    .mode   (mode_q),
    .idx    (idx_q),
    .acc    (acc_q),
    .base   (base_q),
    .wrdata (pat_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      mode_q   <= IDENTITY;
      base_q   <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
    end
  end

  // Next-state and outputs; stall reaches wren directly so a blocked cycle never commits.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    base_d   = base_q;
    stride_d = stride_q;
    rdy      = 1'b0;
    done     = 1'b0;
    wren     = 1'b0;
    addr     = '0;
    wrdata   = '0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d  = FILL;
          idx_d    = '0;
          acc_d    = base;
          mode_d   = fill_mode_t'(mode);
          base_d   = base;
          stride_d = stride;
        end
      end
      FILL: begin
        addr   = idx_q;
        wrdata = pat_data;
        wren   = ~stall;
        if (!stall) begin
          idx_d = idx_q + ADDR_W'(1);
          acc_d = acc_q + stride_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_init_fill.sv
// Scoreboard bench for init_fill: random and directed fills on a 256x8 and a 16x4 instance.
module tb_init_fill;

  localparam int unsigned DEPTH    = 256;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned S_DEPTH  = 16;
  localparam int unsigned S_DATA_W = 4;
  localparam int unsigned S_ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              en = 1'b0, stall = 1'b0, rdy, wren, done;
  logic [1:0]        mode = 2'b00;
  logic [DATA_W-1:0] base = '0, stride = '0, wrdata;
  logic [ADDR_W-1:0] addr;

  logic                s_en = 1'b0, s_stall = 1'b0, s_rdy, s_wren, s_done;
  logic [1:0]          s_mode = 2'b00;
  logic [S_DATA_W-1:0] s_base = '0, s_stride = '0, s_wrdata;
  logic [S_ADDR_W-1:0] s_addr;

  init_fill #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode), .base(base),
    .stride(stride), .stall(stall), .addr(addr), .wrdata(wrdata),
    .wren(wren), .done(done)
  );

  init_fill #(.DEPTH(S_DEPTH), .DATA_W(S_DATA_W), .ADDR_W(S_ADDR_W)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .rdy(s_rdy), .mode(s_mode), .base(s_base),
    .stride(s_stride), .stall(s_stall), .addr(s_addr), .wrdata(s_wrdata),
    .wren(s_wren), .done(s_done)
  );

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t s_q[$];
  int   checks = 0, fails = 0;
  int   done_cnt = 0, s_done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pattern straight from the pattern definitions.
  function automatic int ref_data(input int m, input int b, input int s, input int i);
    case (m)
      0:       return i % 256;
      1:       return b;
      2:       return (b + i * s) % 256;
      default: return 255 - i;
    endcase
  endfunction

  always @(negedge clk) begin : mon_big
    exp_t e;
    if (!rst) begin
      if (wren) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(addr), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(addr), 32'(e.addr));
          chk("wr_data", 32'(wrdata), 32'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_all_written", 32'(exp_q.size()), 0);
        chk("done_wren", 32'(wren), 0);
        chk("done_rdy", 32'(rdy), 0);
      end
    end
  end

  always @(negedge clk) begin : mon_small
    exp_t e;
    if (!rst) begin
      if (s_wren) begin
        if (s_q.size() == 0) chk("s_unexpected_write", 32'(s_addr), 32'hFFFF_FFFF);
        else begin
          e = s_q.pop_front();
          chk("s_wr_addr", 32'(s_addr), 32'(e.addr));
          chk("s_wr_data", 32'(s_wrdata), 32'(e.data));
        end
      end
      if (s_done) begin
        s_done_cnt++;
        chk("s_done_all_written", 32'(s_q.size()), 0);
      end
    end
  end

  task automatic start_fill(input logic [1:0] m, input logic [7:0] b, input logic [7:0] s);
    chk("rdy_before_start", 32'(rdy), 1);
    for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back('{i, ref_data(int'(m), int'(b), int'(s), i)});
    mode = m; base = b; stride = s; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; mode = 2'($urandom); base = 8'($urandom); stride = 8'($urandom);
  endtask

  // stall_mode: 0 none, 1 directed at stall_addr for stall_len cycles, 2 random.
  task automatic run_fill(input int stall_mode, input int stall_addr, input int stall_len,
                          input int busy_addr, output int low, output int nstall);
    int sc = 0;
    bit busy_hit = 1'b0;
    low = 0; nstall = 0;
    while (rdy == 1'b0 && low < 2000) begin
      en = 1'b0; stall = 1'b0;
      if (done == 1'b0) begin
        if (stall_mode == 2) stall = ($urandom_range(0, 3) == 0);
        else if (stall_mode == 1 && int'(addr) == stall_addr && sc < stall_len) begin
          stall = 1'b1; sc++;
        end
        if (stall) nstall++;
        if (busy_addr >= 0 && !busy_hit && int'(addr) == busy_addr) begin
          en = 1'b1; mode = 2'b01; base = 8'($urandom); busy_hit = 1'b1;
        end
      end
      if (stall_mode == 1 && stall) begin
        #2;
        chk("stall_wren", 32'(wren), 0);
        chk("stall_addr_hold", 32'(addr), 32'(stall_addr));
      end
      low++;
      @(posedge clk); #1;
    end
    en = 1'b0; stall = 1'b0;
  endtask

  task automatic fill_and_check(input logic [1:0] m, input logic [7:0] b, input logic [7:0] s,
                                input int stall_mode, input int stall_addr, input int stall_len,
                                input int busy_addr, input int exp_extra);
    int low, ns, d0;
    d0 = done_cnt;
    start_fill(m, b, s);
    run_fill(stall_mode, stall_addr, stall_len, busy_addr, low, ns);
    if (exp_extra >= 0) chk("stall_count", 32'(ns), 32'(exp_extra));
    chk("rdy_low_cycles", 32'(low), 32'(DEPTH + 1 + ns));
    chk("done_pulses", 32'(done_cnt), 32'(d0 + 1));
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n, d0, low;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    chk("rst_s_rdy", 32'(s_rdy), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    fill_and_check(2'b00, 8'($urandom), 8'($urandom), 0, -1, 0, -1, 0);
    fill_and_check(2'b10, 8'h10, 8'h03, 0, -1, 0, -1, 0);
    fill_and_check(2'b11, 8'($urandom), 8'($urandom), 0, -1, 0, -1, 0);
    fill_and_check(2'b01, 8'h5A, 8'($urandom), 0, -1, 0, -1, 0);
    fill_and_check(2'b00, 8'h00, 8'h00, 1, 5, 3, -1, 3);
    fill_and_check(2'b00, 8'h00, 8'h00, 0, -1, 0, 40, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart_rdy", 32'(rdy), 1);

    // Reset in the middle of a fill.
    d0 = done_cnt;
    start_fill(2'b00, 8'h00, 8'h00);
    n = 0;
    while (int'(addr) != 100 && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    chk("reach_idx100", 32'(addr), 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("abort_rdy", 32'(rdy), 1);
    chk("abort_wren", 32'(wren), 0);
    chk("abort_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    fill_and_check(2'b00, 8'h00, 8'h00, 0, -1, 0, -1, 0);

    for (int k = 0; k < 5; k++)
      fill_and_check(2'($urandom), 8'($urandom), 8'($urandom), 2, -1, 0, -1, -1);

    // Narrow instance: 16 entries of 4 bits, identity.
    chk("s_rdy_before", 32'(s_rdy), 1);
    for (int i = 0; i < int'(S_DEPTH); i++) s_q.push_back('{i, i % 16});
    s_mode = 2'b00; s_base = 4'($urandom); s_stride = 4'($urandom); s_en = 1'b1;
    @(posedge clk); #1;
    s_en = 1'b0;
    low = 0;
    while (s_rdy == 1'b0 && low < 200) begin
      low++;
      @(posedge clk); #1;
    end
    chk("s_rdy_low_cycles", 32'(low), 32'(S_DEPTH + 1));
    chk("s_done_pulses", 32'(s_done_cnt), 1);
    chk("s_queue_drained", 32'(s_q.size()), 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
